// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard control unit.
// Holds the FSM state encodings, the forwarding select codes and the hard-wired zero register.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    FREEZE     = 2'b11
  } hazard_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_control_unit_forwarding_unit.sv
// Purely combinational EX-stage operand forwarding selects.
// When both EX/MEM and MEM/WB match, EX/MEM wins because it holds the younger result.
module forwarding_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int RegAddrBits = 5
) (
  input  logic                   EXMEM_RegWrite,
  input  logic [RegAddrBits-1:0] EXMEM_WriteRegister,
  input  logic                   MEMWB_RegWrite,
  input  logic [RegAddrBits-1:0] MEMWB_WriteRegister,
  input  logic [RegAddrBits-1:0] IDEX_Rs,
  input  logic [RegAddrBits-1:0] IDEX_Rt,
  output logic [1:0]             ForwardA,
  output logic [1:0]             ForwardB
);

  logic ex_valid;
  logic mem_valid;

  // Register $0 is hard-wired to zero, so it never forwards.
  assign ex_valid  = EXMEM_RegWrite && (EXMEM_WriteRegister != RegAddrBits'(REG_ZERO));
  assign mem_valid = MEMWB_RegWrite && (MEMWB_WriteRegister != RegAddrBits'(REG_ZERO));

  always_comb begin
    ForwardA = FWD_REG;
    if (ex_valid && (EXMEM_WriteRegister == IDEX_Rs)) begin
      ForwardA = FWD_EX;
    end else if (mem_valid && (MEMWB_WriteRegister == IDEX_Rs)) begin
      ForwardA = FWD_MEM;
    end
  end

  always_comb begin
    ForwardB = FWD_REG;
    if (ex_valid && (EXMEM_WriteRegister == IDEX_Rt)) begin
      ForwardB = FWD_EX;
    end else if (mem_valid && (MEMWB_WriteRegister == IDEX_Rt)) begin
      ForwardB = FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage MIPS core: stalls, flushes, freeze,
// forwarding selects and saturating stall/flush performance counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int RegAddrBits = 5,
  parameter int CounterBits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RegAddrBits-1:0] IFID_Rs,
  input  logic [RegAddrBits-1:0] IFID_Rt,
  input  logic                   IFID_UsesRt,
  input  logic                   JumpControl_ID,
  input  logic                   IDEX_MemRead,
  input  logic [RegAddrBits-1:0] IDEX_Rs,
  input  logic [RegAddrBits-1:0] IDEX_Rt,
  input  logic                   BranchTaken_EX,
  input  logic                   EXMEM_RegWrite,
  input  logic [RegAddrBits-1:0] EXMEM_WriteRegister,
  input  logic                   MEMWB_RegWrite,
  input  logic [RegAddrBits-1:0] MEMWB_WriteRegister,
  input  logic                   DataMemBusy,
  input  logic                   ClearCounters,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IFIDFlush,
  output logic                   IDEXFlush,
  output logic                   PipeEnable,
  output logic [1:0]             ForwardA,
  output logic [1:0]             ForwardB,
  output logic [1:0]             HazardState,
  output logic [CounterBits-1:0] StallCount,
  output logic [CounterBits-1:0] FlushCount
);

  localparam logic [CounterBits-1:0] CountMax = '1;

  hazard_state_e          state_q, state_d;
  logic [CounterBits-1:0] stall_count_q, stall_count_d;
  logic [CounterBits-1:0] flush_count_q, flush_count_d;

  logic       load_use;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_enable;
  logic       stall_inc, flush_inc;
  logic [1:0] fwd_a, fwd_b;

  forwarding_unit #(
    .RegAddrBits(RegAddrBits)
  ) u_forwarding_unit (
    .EXMEM_RegWrite      (EXMEM_RegWrite),
    .EXMEM_WriteRegister (EXMEM_WriteRegister),
    .MEMWB_RegWrite      (MEMWB_RegWrite),
    .MEMWB_WriteRegister (MEMWB_WriteRegister),
    .IDEX_Rs             (IDEX_Rs),
    .IDEX_Rt             (IDEX_Rt),
    .ForwardA            (fwd_a),
    .ForwardB            (fwd_b)
  );

  // Masked in LOAD_STALL so a given load is stalled at most once.
  assign load_use = IDEX_MemRead
                 && (IDEX_Rt != RegAddrBits'(REG_ZERO))
                 && ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)))
                 && (state_q != LOAD_STALL);

  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_enable = 1'b1;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (DataMemBusy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_enable = 1'b0;
      stall_inc   = 1'b1;
      state_d     = FREEZE;
    end else if (BranchTaken_EX) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = FLUSH;
    end else if (JumpControl_ID) begin
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = FLUSH;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      state_d    = LOAD_STALL;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (ClearCounters) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_inc && (stall_count_q != CountMax)) begin
        stall_count_d = stall_count_q + CounterBits'(1);
      end
      if (flush_inc && (flush_count_q != CountMax)) begin
        flush_count_d = flush_count_q + CounterBits'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Reset holds the pipeline still and fills it with bubbles.
  assign PCWrite     = reset && pc_write;
  assign IFIDWrite   = reset && ifid_write;
  assign IFIDFlush   = !reset || ifid_flush;
  assign IDEXFlush   = !reset || idex_flush;
  assign PipeEnable  = reset && pipe_enable;
  assign ForwardA    = reset ? fwd_a : FWD_REG;
  assign ForwardB    = reset ? fwd_b : FWD_REG;
  assign HazardState = state_q;
  assign StallCount  = stall_count_q;
  assign FlushCount  = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit with hand-computed expectations.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_wreg, memwb_wreg;
  logic        ifid_uses_rt, jump_id, idex_mem_read, branch_ex;
  logic        exmem_regwrite, memwb_regwrite, dmem_busy, clear_counters;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_enable;
  logic [1:0]  forward_a, forward_b, hazard_state;
  logic [15:0] stall_count, flush_count;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .IFID_Rs             (ifid_rs),
    .IFID_Rt             (ifid_rt),
    .IFID_UsesRt         (ifid_uses_rt),
    .JumpControl_ID      (jump_id),
    .IDEX_MemRead        (idex_mem_read),
    .IDEX_Rs             (idex_rs),
    .IDEX_Rt             (idex_rt),
    .BranchTaken_EX      (branch_ex),
    .EXMEM_RegWrite      (exmem_regwrite),
    .EXMEM_WriteRegister (exmem_wreg),
    .MEMWB_RegWrite      (memwb_regwrite),
    .MEMWB_WriteRegister (memwb_wreg),
    .DataMemBusy         (dmem_busy),
    .ClearCounters       (clear_counters),
    .PCWrite             (pc_write),
    .IFIDWrite           (ifid_write),
    .IFIDFlush           (ifid_flush),
    .IDEXFlush           (idex_flush),
    .PipeEnable          (pipe_enable),
    .ForwardA            (forward_a),
    .ForwardB            (forward_b),
    .HazardState         (hazard_state),
    .StallCount          (stall_count),
    .FlushCount          (flush_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyIdle();
    ifid_rs = 5'd1; ifid_rt = 5'd2; ifid_uses_rt = 1'b0; jump_id = 1'b0;
    idex_mem_read = 1'b0; idex_rs = 5'd3; idex_rt = 5'd4; branch_ex = 1'b0;
    exmem_regwrite = 1'b0; exmem_wreg = 5'd0; memwb_regwrite = 1'b0; memwb_wreg = 5'd0;
    dmem_busy = 1'b0; clear_counters = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled well away from the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pcwrite"},    32'(pc_write),     32'd0);
    checkOutput({tag, "_ifidwrite"},  32'(ifid_write),   32'd0);
    checkOutput({tag, "_ifidflush"},  32'(ifid_flush),   32'd1);
    checkOutput({tag, "_idexflush"},  32'(idex_flush),   32'd1);
    checkOutput({tag, "_pipeen"},     32'(pipe_enable),  32'd0);
    checkOutput({tag, "_fwda"},       32'(forward_a),    32'd0);
    checkOutput({tag, "_fwdb"},       32'(forward_b),    32'd0);
    checkOutput({tag, "_state"},      32'(hazard_state), 32'd0);
    checkOutput({tag, "_stallcnt"},   32'(stall_count),  32'd0);
  endtask

  initial begin
    applyIdle();
    reset = 1'b0;
    // A forwarding match during reset must still read as 00.
    exmem_regwrite = 1'b1; exmem_wreg = 5'd9; idex_rs = 5'd9; idex_rt = 5'd9;
    #2;
    checkResetOutputs("rst");
    checkOutput("rst_flushcnt", 32'(flush_count), 32'd0);
    #10;
    reset = 1'b1;
    applyIdle();
    stepCycle();
    checkOutput("idle_pcwrite", 32'(pc_write), 32'd1);
    checkOutput("idle_pipeen", 32'(pipe_enable), 32'd1);
    checkOutput("idle_state", 32'(hazard_state), 32'd0);

    // Load-use on rs: one stall cycle, then masked in LOAD_STALL.
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    settle();
    checkOutput("lu_pcwrite", 32'(pc_write), 32'd0);
    checkOutput("lu_ifidwrite", 32'(ifid_write), 32'd0);
    checkOutput("lu_idexflush", 32'(idex_flush), 32'd1);
    checkOutput("lu_ifidflush", 32'(ifid_flush), 32'd0);
    checkOutput("lu_pipeen", 32'(pipe_enable), 32'd1);
    stepCycle();
    checkOutput("lu_state", 32'(hazard_state), 32'd1);
    checkOutput("lu_stallcnt", 32'(stall_count), 32'd1);
    checkOutput("lu_masked_pcwrite", 32'(pc_write), 32'd1);
    checkOutput("lu_masked_idexflush", 32'(idex_flush), 32'd0);
    applyIdle();
    stepCycle();
    checkOutput("lu_back_run", 32'(hazard_state), 32'd0);

    // Load into $0 never stalls.
    idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1;
    settle();
    checkOutput("lu0_pcwrite", 32'(pc_write), 32'd1);
    stepCycle();
    checkOutput("lu0_stallcnt", 32'(stall_count), 32'd1);
    checkOutput("lu0_state", 32'(hazard_state), 32'd0);

    // rt match only counts when the ID instruction reads rt.
    ifid_rs = 5'd3; ifid_rt = 5'd5; idex_rt = 5'd5; ifid_uses_rt = 1'b0;
    settle();
    checkOutput("lurt_unused_pcwrite", 32'(pc_write), 32'd1);
    ifid_uses_rt = 1'b1;
    settle();
    checkOutput("lurt_used_pcwrite", 32'(pc_write), 32'd0);
    stepCycle();
    checkOutput("lurt_stallcnt", 32'(stall_count), 32'd2);
    applyIdle();
    stepCycle();

    // Branch beats jump and load-use in the same cycle.
    branch_ex = 1'b1; jump_id = 1'b1; idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    settle();
    checkOutput("br_ifidflush", 32'(ifid_flush), 32'd1);
    checkOutput("br_idexflush", 32'(idex_flush), 32'd1);
    checkOutput("br_pcwrite", 32'(pc_write), 32'd1);
    checkOutput("br_pipeen", 32'(pipe_enable), 32'd1);
    stepCycle();
    checkOutput("br_flushcnt", 32'(flush_count), 32'd1);
    checkOutput("br_stallcnt", 32'(stall_count), 32'd2);
    checkOutput("br_state", 32'(hazard_state), 32'd2);
    applyIdle();
    settle();
    checkOutput("br_after_pcwrite", 32'(pc_write), 32'd1);
    stepCycle();

    // Jump alone flushes IF/ID only.
    jump_id = 1'b1;
    settle();
    checkOutput("jmp_ifidflush", 32'(ifid_flush), 32'd1);
    checkOutput("jmp_idexflush", 32'(idex_flush), 32'd0);
    checkOutput("jmp_pcwrite", 32'(pc_write), 32'd1);
    stepCycle();
    checkOutput("jmp_flushcnt", 32'(flush_count), 32'd2);
    applyIdle();
    stepCycle();

    // Freeze for three cycles with a pending branch, then the flush goes out.
    dmem_busy = 1'b1; branch_ex = 1'b1;
    settle();
    checkOutput("frz_pipeen", 32'(pipe_enable), 32'd0);
    checkOutput("frz_ifidflush", 32'(ifid_flush), 32'd0);
    checkOutput("frz_idexflush", 32'(idex_flush), 32'd0);
    checkOutput("frz_pcwrite", 32'(pc_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("frz_state", 32'(hazard_state), 32'd3);
      if (i < 2) checkOutput("frz_hold_pipeen", 32'(pipe_enable), 32'd0);
    end
    checkOutput("frz_stallcnt", 32'(stall_count), 32'd5);
    checkOutput("frz_flushcnt_held", 32'(flush_count), 32'd2);
    dmem_busy = 1'b0;
    settle();
    checkOutput("frz_rel_ifidflush", 32'(ifid_flush), 32'd1);
    checkOutput("frz_rel_idexflush", 32'(idex_flush), 32'd1);
    stepCycle();
    checkOutput("frz_rel_flushcnt", 32'(flush_count), 32'd3);
    checkOutput("frz_rel_state", 32'(hazard_state), 32'd2);
    applyIdle();
    stepCycle();

    // Forwarding priority and $0 suppression.
    exmem_regwrite = 1'b1; exmem_wreg = 5'd9; memwb_regwrite = 1'b1; memwb_wreg = 5'd9;
    idex_rs = 5'd9; idex_rt = 5'd9;
    settle();
    checkOutput("fwd_both_a", 32'(forward_a), 32'd2);
    checkOutput("fwd_both_b", 32'(forward_b), 32'd2);
    exmem_regwrite = 1'b0;
    settle();
    checkOutput("fwd_mem_a", 32'(forward_a), 32'd1);
    checkOutput("fwd_mem_b", 32'(forward_b), 32'd1);
    exmem_regwrite = 1'b1; exmem_wreg = 5'd0; memwb_wreg = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
    settle();
    checkOutput("fwd_zero_a", 32'(forward_a), 32'd0);
    checkOutput("fwd_zero_b", 32'(forward_b), 32'd0);
    exmem_wreg = 5'd3; memwb_wreg = 5'd4; idex_rs = 5'd3; idex_rt = 5'd4;
    settle();
    checkOutput("fwd_split_a", 32'(forward_a), 32'd2);
    checkOutput("fwd_split_b", 32'(forward_b), 32'd1);
    applyIdle();
    stepCycle();

    // Clear wins over a same-cycle stall increment.
    clear_counters = 1'b1; dmem_busy = 1'b1;
    stepCycle();
    checkOutput("clr_stallcnt", 32'(stall_count), 32'd0);
    checkOutput("clr_flushcnt", 32'(flush_count), 32'd0);
    clear_counters = 1'b0;
    for (int i = 0; i < 65534; i++) stepCycle();
    checkOutput("sat_pre", 32'(stall_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("sat_hold", 32'(stall_count), 32'h0000_FFFF);
    clear_counters = 1'b1;
    stepCycle();
    checkOutput("sat_clr", 32'(stall_count), 32'd0);
    applyIdle();
    stepCycle();

    // Reset in the middle of LOAD_STALL.
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    stepCycle();
    checkOutput("rstls_pre_state", 32'(hazard_state), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("rstls");
    #2;
    applyIdle();
    reset = 1'b1;
    stepCycle();
    checkOutput("rstls_post_state", 32'(hazard_state), 32'd0);
    checkOutput("rstls_post_pcwrite", 32'(pc_write), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencer for the 5-stage MIPS core. It sits beside the instruction-decode block and drives the PC, IF/ID and ID/EX register enables and flushes. It also drives the EX-stage operand forwarding selects and two saturating performance counters (stall cycles, flush events).
- Handles load-use stalls, taken-branch and jump flushes, and whole-pipeline freeze while data memory is busy.

Parameters:
RegAddrBits, 5, width of register-file addresses
CounterBits, 16, width of StallCount and FlushCount

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
IFID_Rs  input  RegAddrBits  rs field of instruction in ID (Instruction[25:21])
IFID_Rt  input  RegAddrBits  rt field of instruction in ID (Instruction[20:16])
IFID_UsesRt  input  1  ID instruction reads rt (R-type, beq/bne, sw)
JumpControl_ID  input  1  jump/jal/jr decoded in ID
IDEX_MemRead  input  1  EX-stage instruction is a load
IDEX_Rs  input  RegAddrBits  rs of EX-stage instruction
IDEX_Rt  input  RegAddrBits  rt of EX-stage instruction (load destination)
BranchTaken_EX  input  1  beq/bne resolved taken in EX
EXMEM_RegWrite  input  1  MEM-stage instruction writes a register
EXMEM_WriteRegister  input  RegAddrBits  MEM-stage destination
MEMWB_RegWrite  input  1  WB-stage instruction writes a register
MEMWB_WriteRegister  input  RegAddrBits  WB-stage destination
DataMemBusy  input  1  data memory not ready; freeze pipeline
ClearCounters  input  1  synchronous clear of both counters
PCWrite  output  1  PC register enable
IFIDWrite  output  1  IF/ID register enable
IFIDFlush  output  1  load NOP into IF/ID
IDEXFlush  output  1  load bubble (all controls 0) into ID/EX
PipeEnable  output  1  enable for ID/EX, EX/MEM, MEM/WB registers
ForwardA  output  2  EX operand-A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
ForwardB  output  2  EX operand-B select, same encoding
HazardState  output  2  current FSM state (debug)
StallCount  output  CounterBits  load-use stall cycles plus freeze cycles, saturating
FlushCount  output  CounterBits  branch/jump flush events, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - State=RUN; StallCount=0; FlushCount=0.
  - While reset is low, outputs are forced: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, PipeEnable=0, ForwardA=00, ForwardB=00.
- State encoding: RUN=00, LOAD_STALL=01, FLUSH=10, FREEZE=11.
- Control outputs are combinational from state and inputs. State and counters update on the rising edge.
- Per-cycle priority, highest first:
  1. DataMemBusy=1:
     - PCWrite=0, IFIDWrite=0, PipeEnable=0, no flushes.
     - next=FREEZE; StallCount+1.
     - A branch or jump pending during freeze is not lost; it is re-evaluated once DataMemBusy drops.
  2. BranchTaken_EX=1:
     - IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1, PipeEnable=1.
     - next=FLUSH; FlushCount+1.
     - Any simultaneous jump in ID or load-use is ignored (wrong path).
  3. JumpControl_ID=1:
     - IFIDFlush=1, PCWrite=1, PipeEnable=1.
     - next=FLUSH; FlushCount+1.
  4. Load-use condition: IDEX_MemRead & IDEX_Rt!=0 & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)), and state!=LOAD_STALL:
     - PCWrite=0, IFIDWrite=0, IDEXFlush=1, PipeEnable=1.
     - next=LOAD_STALL; StallCount+1.
  5. Otherwise:
     - PCWrite=1, IFIDWrite=1, PipeEnable=1, no flushes; next=RUN.
- LOAD_STALL lasts exactly one cycle. In LOAD_STALL, load-use detection is masked, so a load is never stalled twice.
- FLUSH and FREEZE return to RUN (or another state per the priority list) the next cycle; they carry no extra masking.
- Forwarding, independent of state:
  - ForwardA=10 if EXMEM_RegWrite & EXMEM_WriteRegister!=0 & ==IDEX_Rs.
  - Else ForwardA=01 if MEMWB_RegWrite & MEMWB_WriteRegister!=0 & ==IDEX_Rs.
  - Else ForwardA=00.
  - ForwardB uses the same rules against IDEX_Rt.
  - EX/MEM wins when both stages match.
  - Register $0 never forwards.
- Counters:
  - Saturate at all-ones and never wrap.
  - ClearCounters has priority over increment in the same cycle.
- Reset asserted mid-stall or mid-freeze returns to RUN immediately; there is no residual stall after release.

Decomposition:
- Shared package holds:
  - state encodings RUN/LOAD_STALL/FLUSH/FREEZE;
  - forwarding select constants FWD_REG=00, FWD_MEM=01, FWD_EX=10;
  - REG_ZERO=0.
- One natural sub-module: forwarding_unit, the purely combinational ForwardA/ForwardB logic, instantiated once.
- FSM and counters stay in the top module.

Test Plan:
- lw $t0 in EX (IDEX_MemRead=1, IDEX_Rt=8), ID add with IFID_Rs=8 -> one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1, HazardState=01; next cycle (inputs held) PCWrite=1; StallCount=1.
- lw with IDEX_Rt=0 and IFID_Rs=0 -> no stall, PCWrite=1, StallCount unchanged.
- BranchTaken_EX=1 together with JumpControl_ID=1 and a load-use match -> IFIDFlush=1, IDEXFlush=1, PCWrite=1; FlushCount+1; StallCount unchanged.
- DataMemBusy=1 for 3 cycles while BranchTaken_EX=1 -> PipeEnable=0 and no flush for 3 cycles, StallCount+3, HazardState=11; on release the flush is issued and FlushCount+1.
- EXMEM_WriteRegister=9, MEMWB_WriteRegister=9, both RegWrite=1, IDEX_Rs=9, IDEX_Rt=9 -> ForwardA=10, ForwardB=10; with EXMEM_RegWrite=0 -> 01/01; with destination 0 -> 00/00.
- Preload StallCount to 16'hFFFE via stalls, apply 3 more stall cycles -> holds 16'hFFFF. ClearCounters with a stall in the same cycle -> 0. Assert reset mid-LOAD_STALL -> HazardState=00 and all forced reset outputs.
